// File: rtl/mem_pkg.sv
// Shared constants for the scratch RAM: default geometry and the request op encoding.
package mem_pkg;

    localparam int MEM_SIZE_BYTES = 1024;
    localparam int MEM_WIDTH      = 16;
    localparam int MEM_DEPTH      = 512;
    localparam int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/memory.sv
// Single-port synchronous scratch RAM, one read or write per valid request.
// Latency 1 cycle (registered ready_o/rdata_o); requests always accepted, no back-pressure.
module memory
    import mem_pkg::*;
#(
    parameter int SIZE       = MEM_SIZE_BYTES,
    parameter int WIDTH      = MEM_WIDTH,
    parameter int DEPTH      = MEM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  ready_o
);

    generate
        if (SIZE != DEPTH * WIDTH / 8) begin : g_size_check
            $error("memory: SIZE must equal DEPTH*WIDTH/8");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic             in_range;

    // With a power-of-two depth every encodable address is valid.
    generate
        if (DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_partial_range
            assign in_range = ({1'b0, addr_i} < (ADDR_WIDTH + 1)'(DEPTH));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_o <= 1'b0;
            rdata_o <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (valid_i) begin
            ready_o <= 1'b1;
            if (wr_rd_i == OP_WRITE) begin
                if (in_range) begin
                    mem[addr_i] <= wdata_i;
                end
            end else begin
                rdata_o <= in_range ? mem[addr_i] : '0;
            end
        end else begin
            ready_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory.sv
// Directed self-checking bench for memory: reset, full sweep, handshake timing, RAW, mid-stream reset, boundaries.
module tb_memory;
    import mem_pkg::*;

    localparam int W  = MEM_WIDTH;
    localparam int D  = MEM_DEPTH;
    localparam int AW = MEM_ADDR_WIDTH;

    logic          clk_i;
    logic          rst_i;
    logic          valid_i;
    logic          wr_rd_i;
    logic [AW-1:0] addr_i;
    logic [W-1:0]  wdata_i;
    logic [W-1:0]  rdata_o;
    logic          ready_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] sb [D];
    logic [W-1:0] last_rd;

    memory dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .wr_rd_i (wr_rd_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .ready_o (ready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs change just after a falling edge; outputs are observed at the next falling edge.
    task automatic step(input logic r, input logic v, input logic wr,
                        input int unsigned a, input logic [W-1:0] d);
        rst_i   = r;
        valid_i = v;
        wr_rd_i = wr;
        addr_i  = AW'(a);
        wdata_i = d;
        @(negedge clk_i);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        wr_rd_i = OP_READ;
        addr_i  = '0;
        wdata_i = '0;
        @(negedge clk_i);

        // Reset held for two cycles, with a request presented that must be ignored.
        step(1'b1, 1'b1, OP_WRITE, 7, 16'h1111);
        check("rst_ready_c1", 32'(ready_o), 32'd0);
        check("rst_rdata_c1", 32'(rdata_o), 32'h0);
        step(1'b1, 1'b0, OP_READ, 0, '0);
        check("rst_ready_c2", 32'(ready_o), 32'd0);
        check("rst_rdata_c2", 32'(rdata_o), 32'h0);

        step(1'b0, 1'b1, OP_READ, 0, '0);
        check("rst_rd0_ready", 32'(ready_o), 32'd1);
        check("rst_rd0_data", 32'(rdata_o), 32'h0);
        step(1'b0, 1'b1, OP_READ, 511, '0);
        check("rst_rd511_ready", 32'(ready_o), 32'd1);
        check("rst_rd511_data", 32'(rdata_o), 32'h0);
        step(1'b0, 1'b1, OP_READ, 7, '0);
        check("rst_rd7_data", 32'(rdata_o), 32'h0);

        // Full sweep: writes back to back, rdata_o must hold the last read value.
        for (int i = 0; i < D; i++) begin
            sb[i] = W'($urandom());
            step(1'b0, 1'b1, OP_WRITE, i, sb[i]);
            check("sweep_wr_ready", 32'(ready_o), 32'd1);
            check("sweep_wr_hold", 32'(rdata_o), 32'h0);
        end
        for (int i = 0; i < D; i++) begin
            step(1'b0, 1'b1, OP_READ, i, W'($urandom()));
            check("sweep_rd_ready", 32'(ready_o), 32'd1);
            check("sweep_rd_data", 32'(rdata_o), 32'(sb[i]));
        end
        last_rd = sb[D-1];

        step(1'b0, 1'b0, OP_WRITE, 9, 16'hDEAD);
        check("idle_ready", 32'(ready_o), 32'd0);
        check("idle_hold", 32'(rdata_o), 32'(last_rd));
        step(1'b0, 1'b1, OP_READ, 9, '0);
        check("idle_nowrite", 32'(rdata_o), 32'(sb[9]));

        // Handshake timing around a single read of addr 5.
        step(1'b0, 1'b1, OP_WRITE, 5, 16'hBEEF);
        check("hs_wr_ready", 32'(ready_o), 32'd1);
        step(1'b0, 1'b0, OP_READ, 0, '0);
        check("hs_gap_ready", 32'(ready_o), 32'd0);
        step(1'b0, 1'b1, OP_READ, 5, '0);
        check("hs_rd_ready", 32'(ready_o), 32'd1);
        check("hs_rd_data", 32'(rdata_o), 32'hBEEF);
        step(1'b0, 1'b0, OP_READ, 0, '0);
        check("hs_after_ready", 32'(ready_o), 32'd0);
        check("hs_after_data", 32'(rdata_o), 32'hBEEF);
        step(1'b0, 1'b0, OP_WRITE, 5, 16'h0);
        check("hs_after2_ready", 32'(ready_o), 32'd0);
        check("hs_after2_data", 32'(rdata_o), 32'hBEEF);

        // Read-after-write on consecutive cycles.
        step(1'b0, 1'b1, OP_WRITE, 10, 16'h1234);
        check("raw_wr_hold", 32'(rdata_o), 32'hBEEF);
        check("raw_wr_ready", 32'(ready_o), 32'd1);
        step(1'b0, 1'b1, OP_READ, 10, '0);
        check("raw_rd_data", 32'(rdata_o), 32'h1234);
        check("raw_rd_ready", 32'(ready_o), 32'd1);

        // Reset arriving together with a write: write dropped, all words cleared.
        step(1'b0, 1'b1, OP_WRITE, 3, 16'hAAAA);
        step(1'b1, 1'b1, OP_WRITE, 4, 16'h5555);
        check("mrst_ready", 32'(ready_o), 32'd0);
        check("mrst_rdata", 32'(rdata_o), 32'h0);
        step(1'b0, 1'b1, OP_READ, 3, '0);
        check("mrst_rd3", 32'(rdata_o), 32'h0);
        check("mrst_rd3_ready", 32'(ready_o), 32'd1);
        step(1'b0, 1'b1, OP_READ, 4, '0);
        check("mrst_rd4", 32'(rdata_o), 32'h0);
        step(1'b0, 1'b1, OP_READ, 10, '0);
        check("mrst_rd10", 32'(rdata_o), 32'h0);

        // Boundary addresses, checking for aliasing between the two ends.
        step(1'b0, 1'b1, OP_WRITE, 511, 16'hFFFF);
        step(1'b0, 1'b1, OP_WRITE, 0, 16'h0001);
        step(1'b0, 1'b1, OP_READ, 511, '0);
        check("bnd_rd511", 32'(rdata_o), 32'hFFFF);
        step(1'b0, 1'b1, OP_READ, 0, '0);
        check("bnd_rd0", 32'(rdata_o), 32'h0001);
        step(1'b0, 1'b1, OP_READ, 256, '0);
        check("bnd_rd256", 32'(rdata_o), 32'h0);
        step(1'b0, 1'b1, OP_READ, 255, '0);
        check("bnd_rd255", 32'(rdata_o), 32'h0);
        step(1'b0, 1'b0, OP_READ, 0, '0);
        check("end_ready", 32'(ready_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
